pulse_meter: RTL and testbench

Cycle-accurate pulse-width meter that sits directly downstream of the 2-input NAND gate stage and consumes its single-bit output. It synchronises the gate output into the clock domain, detects each transition, and reports the duration of every completed high or low interval in clock cycles over a valid/ready result interface. Its purpose is to check the gate's timing against its stimulus in hardware: input-to-output delay and output pulse widths.

---
 rtl/pulse_meter_pkg.sv | 21 ++
 rtl/pulse_meter_if.sv | 30 +++
 rtl/pulse_meter_bit_sync.sv | 29 ++
 rtl/pulse_meter.sv | 144 ++++++++++++++
 tb/tb_pulse_meter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse-width meter.
package pulse_meter_pkg;

  // Default counter width. Top-level instances may override it.
  localparam int CNT_W_DEF = 16;

  // Measurement FSM states.
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // One completed interval at the default counter width.
  // Narrower instances zero-extend their width into this struct.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] width;
    logic                 level;
    logic                 sat;
  } meas_res_t;

endpackage

// File: rtl/pulse_meter_if.sv
// Valid/ready result channel of the pulse-width meter.
interface pulse_meter_if #(
  parameter int CNT_W = 16
) ();

  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] meas_width;
  logic             meas_level;
  logic             meas_sat;

  // The meter drives the result side.
  modport master (
    output meas_valid,
    output meas_width,
    output meas_level,
    output meas_sat,
    input  meas_ready
  );

  // The consumer accepts results.
  modport slave (
    input  meas_valid,
    input  meas_width,
    input  meas_level,
    input  meas_sat,
    output meas_ready
  );

endinterface

// File: rtl/pulse_meter_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit. The chain resets to 0.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // The first stage captures the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) chain_q[0] <= 1'b0;
    else     chain_q[0] <= d_i;
  end

  // Each later stage re-samples the stage before it.
  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) chain_q[gi] <= 1'b0;
      else     chain_q[gi] <= chain_q[gi-1];
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pulse_meter.sv
// Pulse-width meter. It synchronises a gate output and times every completed
// high/low interval in clock cycles. Each result goes out on a valid/ready
// channel.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sig_in,
  output logic          overrun,
  pulse_meter_if.master meas
);

  typedef struct packed {
    logic [CNT_W-1:0] width;
    logic             level;
    logic             sat;
  } res_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s;
  logic             s_d_q;
  logic             edge_det;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             new_res;
  res_t             new_val;

  res_t             res_q, res_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             transfer;
  logic             load;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sig_in),
    .q_o (s)
  );

  // Keep a one-cycle-delayed copy of the synchronised level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) s_d_q <= 1'b0;
    else     s_d_q <= s;
  end

  assign edge_det = s ^ s_d_q;

  // FSM, counter and saturation flag state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state logic. The first edge only arms the counter, because that
  // interval's start is unknown. Later edges close the running interval.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    new_res = 1'b0;
    new_val = '{width: cnt_q, level: s_d_q, sat: sat_q};

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (edge_det) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
            sat_d   = 1'b0;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            new_res = 1'b1;
            cnt_d   = CNT_ONE;
            sat_d   = 1'b0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q + CNT_ONE == CNT_MAX) sat_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Result channel. A new result loads only into an empty or draining
  // register. Otherwise it is dropped and the sticky overrun flag is set.
  always_comb begin
    transfer  = valid_q & meas.meas_ready;
    load      = new_res & (~valid_q | transfer);
    res_d     = res_q;
    valid_d   = valid_q;
    overrun_d = overrun_q | (new_res & ~load);
    if (load) begin
      res_d   = new_val;
      valid_d = 1'b1;
    end else if (transfer) begin
      valid_d = 1'b0;
    end
  end

  // Result and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      res_q     <= res_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign meas.meas_valid = valid_q;
  assign meas.meas_width = res_q.width;
  assign meas.meas_level = res_q.level;
  assign meas.meas_sat   = res_q.sat;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter. Expected results go into a queue when
// stimulus is driven, and are popped when the DUT transfers a result.
module tb_pulse_meter;
  import pulse_meter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en, sig_in, overrun;
  logic en4, sig4, overrun4;

  int n_checks = 0;
  int n_errors = 0;

  meas_res_t exp_q[$];
  meas_res_t exp4_q[$];

  pulse_meter_if #(.CNT_W(16)) pm_if ();
  pulse_meter_if #(.CNT_W(4))  pm_if4 ();

  pulse_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sig_in  (sig_in),
    .overrun (overrun),
    .meas    (pm_if.master)
  );

  pulse_meter #(.CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .en      (en4),
    .sig_in  (sig4),
    .overrun (overrun4),
    .meas    (pm_if4.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic meas_res_t mk(input int w, input logic l, input logic s);
    meas_res_t r;
    r.width = 16'(w);
    r.level = l;
    r.sat   = s;
    return r;
  endfunction

  // Wait n cycles. With lat set, also check that meas_valid rises exactly
  // 3 clocks after the preceding sig_in change.
  task automatic hold(input int n, input bit lat);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (lat && i <= 3) begin
        #2;
        check($sformatf("latency_valid_c%0d", i), 32'(pm_if.meas_valid), 32'(i == 3));
      end
    end
  endtask

  // Check every result output of the main DUT against the given values.
  task automatic check_outputs(input string tag, input logic v, input int w, input logic l,
                               input logic s, input logic o);
    check({tag, "_valid"},   32'(pm_if.meas_valid), 32'(v));
    check({tag, "_width"},   32'(pm_if.meas_width), 32'(w));
    check({tag, "_level"},   32'(pm_if.meas_level), 32'(l));
    check({tag, "_sat"},     32'(pm_if.meas_sat),   32'(s));
    check({tag, "_overrun"}, 32'(overrun),          32'(o));
  endtask

  // Scoreboard for the 16-bit DUT: compare on every transfer.
  always begin
    meas_res_t e;
    @(negedge clk);
    #2;
    if (!rst && pm_if.meas_valid && pm_if.meas_ready) begin
      check("result_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("result: width=%0d level=%0d sat=%0d (exp width=%0d level=%0d sat=%0d)",
                 pm_if.meas_width, pm_if.meas_level, pm_if.meas_sat, e.width, e.level, e.sat);
        check("width", 32'(pm_if.meas_width), 32'(e.width));
        check("level", 32'(pm_if.meas_level), 32'(e.level));
        check("sat",   32'(pm_if.meas_sat),   32'(e.sat));
      end
    end
  end

  // Scoreboard for the 4-bit DUT.
  always begin
    meas_res_t e;
    @(negedge clk);
    #2;
    if (!rst && pm_if4.meas_valid && pm_if4.meas_ready) begin
      check("result4_expected", 32'(exp4_q.size() > 0), 32'd1);
      if (exp4_q.size() > 0) begin
        e = exp4_q.pop_front();
        $display("result4: width=%0d level=%0d sat=%0d (exp width=%0d level=%0d sat=%0d)",
                 pm_if4.meas_width, pm_if4.meas_level, pm_if4.meas_sat, e.width, e.level, e.sat);
        check("width4", 32'(pm_if4.meas_width), 32'(e.width));
        check("level4", 32'(pm_if4.meas_level), 32'(e.level));
        check("sat4",   32'(pm_if4.meas_sat),   32'(e.sat));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = 1'b0; en4 = 1'b0; sig4 = 1'b0;
    pm_if.meas_ready = 1'b1; pm_if4.meas_ready = 1'b1;
    hold(3, 0);
    rst = 1'b0;
    #2;
    check_outputs("reset", 0, 0, 0, 0, 0);
    check("reset4_valid", 32'(pm_if4.meas_valid), 32'd0);

    // Saturation on the 4-bit instance.
    en4 = 1'b1; hold(2, 0);
    sig4 = 1'b1; hold(20, 0);
    sig4 = 1'b0; exp4_q.push_back(mk(15, 1'b1, 1'b1)); hold(6, 0);
    sig4 = 1'b1; exp4_q.push_back(mk(6, 1'b0, 1'b0)); hold(4, 0);
    en4 = 1'b0; hold(2, 0);

    // Basic intervals, with latency checks.
    en = 1'b1; hold(3, 0);
    sig_in = 1'b1; hold(6, 0);
    sig_in = 1'b0; exp_q.push_back(mk(6, 1'b1, 1'b0)); hold(5, 1);
    sig_in = 1'b1; exp_q.push_back(mk(5, 1'b0, 1'b0)); hold(4, 1);
    en = 1'b0; hold(2, 0);

    // Backpressure and overrun.
    pm_if.meas_ready = 1'b0; en = 1'b1; hold(2, 0);
    sig_in = 1'b0; hold(3, 0);
    sig_in = 1'b1; exp_q.push_back(mk(3, 1'b0, 1'b0)); hold(3, 0);
    check_outputs("bp_first", 1, 3, 0, 0, 0);
    sig_in = 1'b0; hold(3, 0);
    check_outputs("bp_second", 1, 3, 0, 0, 1);
    sig_in = 1'b1; hold(3, 0);
    check_outputs("bp_third", 1, 3, 0, 0, 1);
    pm_if.meas_ready = 1'b1;
    @(negedge clk); #2;
    check("bp_drained_valid", 32'(pm_if.meas_valid), 32'd0);
    en = 1'b0; hold(2, 0);

    // Transfer and load in the same cycle.
    pm_if.meas_ready = 1'b0; en = 1'b1; hold(2, 0);
    sig_in = 1'b0; hold(4, 0);
    sig_in = 1'b1; exp_q.push_back(mk(4, 1'b0, 1'b0)); hold(5, 0);
    check_outputs("tl_pending", 1, 4, 0, 0, 1);
    sig_in = 1'b0; exp_q.push_back(mk(5, 1'b1, 1'b0));
    @(negedge clk);
    @(negedge clk);
    pm_if.meas_ready = 1'b1;
    @(negedge clk);
    pm_if.meas_ready = 1'b0;
    #2;
    check_outputs("tl_no_gap", 1, 5, 1, 0, 1);
    pm_if.meas_ready = 1'b1; hold(2, 0);
    en = 1'b0; hold(2, 0);

    // Enable drop mid-interval.
    en = 1'b1; hold(2, 0);
    sig_in = 1'b1; hold(4, 0);
    en = 1'b0; hold(3, 0);
    en = 1'b1; hold(3, 0);
    check("en_drop_no_result", 32'(pm_if.meas_valid), 32'd0);
    sig_in = 1'b0; hold(7, 0);
    check("en_rearm_no_result", 32'(pm_if.meas_valid), 32'd0);
    sig_in = 1'b1; exp_q.push_back(mk(7, 1'b0, 1'b0)); hold(7, 1);
    en = 1'b0; hold(2, 0);

    // Reset mid-operation while a result is pending and overrun is set.
    pm_if.meas_ready = 1'b0; en = 1'b1; hold(2, 0);
    sig_in = 1'b0; hold(3, 0);
    sig_in = 1'b1; hold(3, 0);
    sig_in = 1'b0; hold(3, 0);
    check("pre_reset_valid",   32'(pm_if.meas_valid), 32'd1);
    check("pre_reset_overrun", 32'(overrun),          32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_outputs("mid_reset", 0, 0, 0, 0, 0);
    pm_if.meas_ready = 1'b1;
    sig_in = 1'b1; hold(5, 0);
    check("post_reset_arm_only", 32'(pm_if.meas_valid), 32'd0);
    sig_in = 1'b0; exp_q.push_back(mk(5, 1'b1, 1'b0)); hold(4, 1);

    hold(3, 0);
    check("queue_empty",  32'(exp_q.size()),  32'd0);
    check("queue4_empty", 32'(exp4_q.size()), 32'd0);
    check("overrun4_clear", 32'(overrun4), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
